pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage. Holds the current PC and selects the next one from sequential increment, resolved branch/jump redirect, trap vector or exception-return address. Keeps the exception PC (EPC) and, optionally, a return-address stack (RAS) for call/return prediction. It feeds the instruction memory and the IF/ID pipeline register, with stall control from the hazard detection unit.

---
 rtl/pc_unit_if.sv | 39 +++
 rtl/pc_unit.sv | 157 +++++++++++++++
 tb/tb_pc_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_unit_if.sv
// Fetch-stage program-counter bus.
// Groups every non-clock, non-reset signal of pc_unit.
//   master : hazard unit / pipeline side. Drives the flush, stall and predecode controls
//            and receives the PC, EPC and status.
//   slave  : pc_unit. Receives the controls and drives the outputs.
// Parameters XLEN and RAS_DEPTH must match the pc_unit instance attached to this bus.
interface pc_unit_if #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned RAS_DEPTH = 8
);
  localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;

  logic            pc_write;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            mret_valid;
  logic            is_call;
  logic            is_ret;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] epc_out;
  logic            misaligned;
  logic            ras_hit;
  logic [CntW-1:0] ras_count;

  modport master (
    output pc_write, redirect_valid, redirect_target, trap_valid, trap_pc, mret_valid,
           is_call, is_ret,
    input  pc_out, pc_plus4, epc_out, misaligned, ras_hit, ras_count
  );

  modport slave (
    input  pc_write, redirect_valid, redirect_target, trap_valid, trap_pc, mret_valid,
           is_call, is_ret,
    output pc_out, pc_plus4, epc_out, misaligned, ras_hit, ras_count
  );
endinterface

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// Selects the next PC with the following priority, highest first:
//   1. trap
//   2. mret
//   3. redirect
//   4. stall
//   5. RAS-predicted return
//   6. pc + 4
// The unit also holds the exception PC.
// Optional return-address stack: build with the macro PC_RAS_EN defined. Without it, is_call and
// is_ret are ignored, and ras_hit and ras_count read 0.
// Ports:
//   clk   : rising-edge clock.
//   reset : asynchronous, active-high.
//   bus   : pc_unit_if.slave.
//     Inputs  : pc_write, redirect_valid/target, trap_valid, trap_pc, mret_valid,
//               is_call, is_ret.
//     Outputs : pc_out, pc_plus4 (combinational), epc_out, misaligned, ras_hit, ras_count.
module pc_unit #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int unsigned     RAS_DEPTH    = 8
) (
  input logic      clk,
  input logic      reset,
  pc_unit_if.slave bus
);
  localparam int unsigned CntW = $clog2(RAS_DEPTH) + 1;
  localparam int unsigned PtrW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic            misaligned_q, misaligned_d;
  logic            ras_hit_q, ras_hit_d;
  logic [XLEN-1:0] pc_plus4;
  logic            seq_adv;    // pc_write path taken: the only cycle the RAS may move
  logic            ras_clear;
  logic            ras_pred_valid;
  logic [XLEN-1:0] ras_pred;

  assign pc_plus4 = pc_q + XLEN'(4);

  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    misaligned_d = 1'b0;
    ras_hit_d    = 1'b0;
    seq_adv      = 1'b0;
    ras_clear    = 1'b0;
    if (bus.trap_valid) begin
      pc_d      = TRAP_VECTOR;
      epc_d     = bus.trap_pc;
      ras_clear = 1'b1;
    end else if (bus.mret_valid) begin
      pc_d = epc_q;
    end else if (bus.redirect_valid) begin
      if (bus.redirect_target[1:0] == 2'b00) begin
        pc_d = bus.redirect_target;
      end else begin
        misaligned_d = 1'b1;
      end
    end else if (bus.pc_write) begin
      seq_adv = 1'b1;
      if (ras_pred_valid) begin
        pc_d      = ras_pred;
        ras_hit_d = 1'b1;
      end else begin
        pc_d = pc_plus4;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q         <= RESET_VECTOR;
      epc_q        <= '0;
      misaligned_q <= 1'b0;
      ras_hit_q    <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      misaligned_q <= misaligned_d;
      ras_hit_q    <= ras_hit_d;
    end
  end

`ifdef PC_RAS_EN
  // Circular stack. top_q indexes the newest entry, and cnt_q counts the valid entries.
  // When the stack is full, the pointer wraps and overwrites the oldest entry.
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [PtrW-1:0] top_q, top_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ras_we;
  logic [PtrW-1:0] ras_widx;
  logic            ras_nonempty;

  assign ras_nonempty   = (cnt_q != '0);
  assign ras_pred_valid = bus.is_ret && ras_nonempty;
  assign ras_pred       = ras_q[top_q];

  always_comb begin
    top_d    = top_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = top_q;
    if (ras_clear) begin
      cnt_d = '0;
    end else if (seq_adv) begin
      if (bus.is_call && bus.is_ret && ras_nonempty) begin
        // Predict from the old top, then replace it in place.
        ras_we = 1'b1;
      end else if (bus.is_call) begin
        top_d    = top_q + PtrW'(1);
        ras_widx = top_q + PtrW'(1);
        ras_we   = 1'b1;
        if (cnt_q != CntW'(RAS_DEPTH)) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end else if (bus.is_ret && ras_nonempty) begin
        top_d = top_q - PtrW'(1);
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_q[ras_widx] <= pc_plus4;
    end
  end

  assign bus.ras_count = cnt_q;
`else
  logic unused_ras;
  assign unused_ras     = ^{bus.is_call, bus.is_ret, seq_adv, ras_clear};
  assign ras_pred_valid = 1'b0;
  assign ras_pred       = '0;
  assign bus.ras_count  = '0;
`endif

  assign bus.pc_out     = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.epc_out    = epc_q;
  assign bus.misaligned = misaligned_q;
  assign bus.ras_hit    = ras_hit_q;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  localparam int unsigned XLEN      = 64;
  localparam int unsigned RAS_DEPTH = 8;
  localparam logic [63:0] RST_VEC   = 64'h0;
  localparam logic [63:0] TRAP_VEC  = 64'h100;
`ifdef PC_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pc_unit_if #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) bus ();

  pc_unit #(
    .XLEN        (XLEN),
    .RESET_VECTOR(RST_VEC),
    .TRAP_VECTOR (TRAP_VEC),
    .RAS_DEPTH   (RAS_DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural PC state plus a bounded LIFO held in a queue.
  logic [63:0] m_pc, m_epc;
  bit          m_mis, m_hit;
  logic [63:0] m_ras[$];

  task automatic model_reset();
    m_pc  = RST_VEC;
    m_epc = 64'h0;
    m_mis = 1'b0;
    m_hit = 1'b0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [63:0] seq;
    bit          pred;
    seq   = m_pc + 64'd4;
    m_mis = 1'b0;
    m_hit = 1'b0;
    if (bus.trap_valid) begin
      m_pc  = TRAP_VEC;
      m_epc = bus.trap_pc;
      m_ras.delete();
    end else if (bus.mret_valid) begin
      m_pc = m_epc;
    end else if (bus.redirect_valid) begin
      if (bus.redirect_target % 4 == 0) m_pc = bus.redirect_target;
      else m_mis = 1'b1;
    end else if (bus.pc_write) begin
      pred = RasEn && bus.is_ret && (m_ras.size() > 0);
      m_hit = pred;
      m_pc  = pred ? m_ras[$] : seq;
      if (RasEn && bus.is_call) begin
        if (pred) begin
          m_ras[m_ras.size()-1] = seq;
        end else begin
          if (m_ras.size() == RAS_DEPTH) void'(m_ras.pop_front());
          m_ras.push_back(seq);
        end
      end else if (pred) begin
        void'(m_ras.pop_back());
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"}, bus.pc_out, m_pc);
    check({tag, ".pc4"}, bus.pc_plus4, m_pc + 64'd4);
    check({tag, ".epc"}, bus.epc_out, m_epc);
    check({tag, ".mis"}, 64'(bus.misaligned), 64'(m_mis));
    check({tag, ".hit"}, 64'(bus.ras_hit), 64'(m_hit));
    check({tag, ".cnt"}, 64'(bus.ras_count), 64'(m_ras.size()));
  endtask

  task automatic idle_inputs();
    bus.pc_write        = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.trap_valid      = 1'b0;
    bus.trap_pc         = '0;
    bus.mret_valid      = 1'b0;
    bus.is_call         = 1'b0;
    bus.is_ret          = 1'b0;
  endtask

  // Inputs are already driven; advance one edge, then compare away from the edge.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    idle_inputs();
  endtask

  task automatic redirect_to(input logic [63:0] t);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = t;
    cycle("redir");
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Sequential fetch: 4, 8, 12
    for (int i = 0; i < 3; i++) begin
      bus.pc_write = 1'b1;
      cycle("seq");
    end
    check("seq_end", bus.pc_out, 64'd12);

    // Asynchronous reset mid-run
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("async_rst_pc", bus.pc_out, RST_VEC);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Redirect while stalled, then a misaligned target
    redirect_to(64'h40);
    redirect_to(64'h200);
    redirect_to(64'h40);
    redirect_to(64'h202);
    check("mis_hold", bus.pc_out, 64'h40);
    cycle("mis_clear");

    // Trap beats redirect; mret returns to the newly saved epc
    bus.trap_valid      = 1'b1;
    bus.trap_pc         = 64'h88;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 64'h400;
    bus.mret_valid      = 1'b1;
    cycle("trap");
    bus.mret_valid = 1'b1;
    cycle("mret");

    // Call at 0x10, return at 0x300
    redirect_to(64'h10);
    bus.pc_write = 1'b1;
    bus.is_call  = 1'b1;
    cycle("call");
    redirect_to(64'h300);
    bus.pc_write = 1'b1;
    bus.is_ret   = 1'b1;
    cycle("ret");

    // Overflow: 9 calls, then 9 returns
    for (int i = 0; i < 9; i++) begin
      redirect_to(64'h1000 + 64'(i) * 64'h100);
      bus.pc_write = 1'b1;
      bus.is_call  = 1'b1;
      cycle("ovf_call");
    end
    for (int i = 0; i < 9; i++) begin
      redirect_to(64'h8000);
      bus.pc_write = 1'b1;
      bus.is_ret   = 1'b1;
      cycle("ovf_ret");
    end

    // Wrap modulo 2^XLEN
    redirect_to(64'hFFFF_FFFF_FFFF_FFFC);
    bus.pc_write = 1'b1;
    cycle("wrap");
    check("wrap_zero", bus.pc_out, 64'h0);

    // Random stimulus
    for (int i = 0; i < 1500; i++) begin
      bus.trap_valid      = ($urandom_range(0, 31) == 0);
      bus.trap_pc         = {32'h0, $urandom};
      bus.mret_valid      = ($urandom_range(0, 19) == 0);
      bus.redirect_valid  = ($urandom_range(0, 7) == 0);
      bus.redirect_target = {32'h0, $urandom & 32'h0000_FFFF};
      if ($urandom_range(0, 3) != 0) bus.redirect_target[1:0] = 2'b00;
      bus.pc_write        = ($urandom_range(0, 3) != 0);
      bus.is_call         = ($urandom_range(0, 4) == 0);
      bus.is_ret          = ($urandom_range(0, 4) == 0);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
